// File: rtl/ap_hs_pkg.sv
// rtl/ap_hs_pkg.sv - shared types and reference helpers for ap_hs_responder
package ap_hs_pkg;

  // Control states of the responder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ap_hs_state_e;

  // Cycles a job costs on top of its argument (accept + final RUN + DONE)
  localparam int unsigned JOB_OVERHEAD = 3;

  // Reference result of one job: n*(n+1)/2
  function automatic longint unsigned tri_sum(input longint unsigned n);
    return (n * (n + 64'd1)) / 64'd2;
  endfunction

  // Minimum start-to-start period of back-to-back jobs with argument arg
  function automatic int unsigned job_period(input int unsigned arg);
    return arg + JOB_OVERHEAD;
  endfunction

endpackage

// File: rtl/ap_hs_slave_fsm.sv
// rtl/ap_hs_slave_fsm.sv - ap_ctrl_hs responder control FSM
module ap_hs_slave_fsm
  import ap_hs_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_start,
  input  logic cnt_zero,
  output logic load_en,
  output logic run_en,
  output logic finish_en,
  output logic ap_ready,
  output logic ap_done,
  output logic ap_idle
);

  ap_hs_state_e state_q, state_d;

  // Next-state selection: accept in IDLE, iterate in RUN, single DONE cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any job in flight
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs follow the state directly so they line up with it.
  // ap_start in DONE is ignored because only IDLE looks at it.
  assign load_en   = (state_q == IDLE) && ap_start;
  assign run_en    = (state_q == RUN) && !cnt_zero;
  assign finish_en = (state_q == RUN) && cnt_zero;
  assign ap_idle   = (state_q == IDLE);
  assign ap_ready  = (state_q == DONE);
  assign ap_done   = (state_q == DONE);

endmodule

// File: rtl/ap_hs_responder.sv
// rtl/ap_hs_responder.sv - ap_ctrl_hs responder computing an iterative triangular sum
module ap_hs_responder
  import ap_hs_pkg::*;
#(
  parameter int ARG_W = 8,
  parameter int RET_W = 2 * ARG_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  input  logic [ARG_W-1:0] ap_arg,
  output logic [RET_W-1:0] ap_return
);

  logic load_en, run_en, finish_en, cnt_zero;

  logic [ARG_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] acc_q, acc_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic [RET_W-1:0] cnt_ext;

  ap_hs_slave_fsm u_fsm (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .cnt_zero  (cnt_zero),
    .load_en   (load_en),
    .run_en    (run_en),
    .finish_en (finish_en),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle)
  );

  assign cnt_zero = (cnt_q == '0);
  // Accumulator is as wide as the result, so the largest argument cannot overflow
  assign cnt_ext  = {{(RET_W-ARG_W){1'b0}}, cnt_q};

  // Datapath: capture argument on accept, add-and-count-down while running,
  // publish the sum on the transition into DONE
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    ret_d = ret_q;
    if (load_en) begin
      cnt_d = ap_arg;
      acc_d = '0;
    end
    if (run_en) begin
      acc_d = acc_q + cnt_ext;
      cnt_d = cnt_q - ARG_W'(1);
    end
    if (finish_en) begin
      ret_d = acc_q;
    end
  end

  // Datapath registers; reset also clears a previously published result
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      ret_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ret_q <= ret_d;
    end
  end

  assign ap_return = ret_q;

endmodule

// File: tb/tb_ap_hs_responder.sv
// tb/tb_ap_hs_responder.sv - scoreboard bench for ap_hs_responder
module tb_ap_hs_responder;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic [7:0]  ap_arg;
  logic [15:0] ap_return;

  typedef struct {
    int ret;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   pend;

  ap_hs_responder #(.ARG_W(8), .RET_W(16)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_arg    (ap_arg),
    .ap_return (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  // Cycle index: value seen after a rising edge names the cycle that edge opens
  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push(input int ret, input int at);
    exp_t e;
    e.ret = ret;
    e.cyc = at;
    exp_q.push_back(e);
  endfunction

  // Monitor: compares every completion against the scoreboard
  always @(negedge ap_clk) begin : monitor
    exp_t e;
    if (ap_rst === 1'b0) begin
      check("ready_eq_done", {63'd0, ap_ready}, {63'd0, ap_done});
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_done: no ap_done, expected at cycle %0d ret %0d", e.cyc, e.ret);
      end
      if (ap_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: ap_done at cycle %0d ret %0d, expected none", cyc, ap_return);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("ap_return", 64'(ap_return), 64'(e.ret));
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (ap_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got no ap_ready expected one within %0d cycles", limit);
    end
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle
  task automatic run_job(input int arg, input int ret);
    ap_arg   = 8'(arg);
    ap_start = 1'b1;
    push(ret, cyc + arg + 2);
    wait_ready(arg + 10);
    ap_start = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a;
    ap_rst   = 1'b1;
    ap_start = 1'b1;
    ap_arg   = 8'd3;
    pend     = 1'b0;
    repeat (3) tick();
    check("rst_idle", {63'd0, ap_idle}, 64'd1);
    check("rst_done", {63'd0, ap_done}, 64'd0);
    check("rst_ready", {63'd0, ap_ready}, 64'd0);
    check("rst_return", 64'(ap_return), 64'd0);

    // 1: start held through reset, accepted in the first non-reset cycle
    ap_rst = 1'b0;
    a = cyc;
    push(6, a + 5);
    tick();
    check("t1_busy_c1", {63'd0, ap_idle}, 64'd0);
    wait_ready(20);
    ap_start = 1'b0;
    tick();
    tick();
    check("t1_return_held", 64'(ap_return), 64'd6);
    check("t1_idle_after", {63'd0, ap_idle}, 64'd1);

    // 2: boundary arguments
    run_job(0, 0);
    run_job(255, 32640);
    check("t2_return_held", 64'(ap_return), 64'd32640);

    // 3: start held continuously, arg=1 -> one job every 4 cycles
    a = cyc;
    ap_arg   = 8'd1;
    ap_start = 1'b1;
    push(1, a + 3);
    push(1, a + 7);
    push(1, a + 11);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t3_idle_k%0d", k), {63'd0, ap_idle}, (k % 4 == 0) ? 64'd1 : 64'd0);
      if (k == 9) ap_start = 1'b0;
      tick();
    end
    check("t3_idle_end", {63'd0, ap_idle}, 64'd1);
    tick();

    // 4: argument change and start drop during RUN
    a = cyc;
    ap_arg   = 8'd10;
    ap_start = 1'b1;
    push(55, a + 12);
    tick();
    tick();
    ap_arg   = 8'd200;
    ap_start = 1'b0;
    repeat (12) tick();
    check("t4_idle", {63'd0, ap_idle}, 64'd1);
    check("t4_return", 64'(ap_return), 64'd55);
    repeat (4) tick();

    // 5: reset in cycle 4 of an arg=10 job
    a = cyc;
    ap_arg   = 8'd10;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (3) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("t5_idle_after_rst", {63'd0, ap_idle}, 64'd1);
    check("t5_return_cleared", 64'(ap_return), 64'd0);
    repeat (12) tick();
    check("t5_no_restart", {63'd0, ap_idle}, 64'd1);
    run_job(2, 3);

    // 6: initiator-style closed loop with a second trigger during RUN
    a = cyc;
    ap_arg   = 8'd4;
    ap_start = 1'b1;
    push(10, a + 6);
    tick();
    tick();
    pend = 1'b1;
    wait_ready(20);
    if (pend) begin
      ap_arg = 8'd3;
      push(6, a + 12);
      pend = 1'b0;
    end else begin
      ap_start = 1'b0;
    end
    tick();
    tick();
    ap_start = 1'b0;
    wait_ready(20);
    repeat (6) tick();
    check("t6_idle_end", {63'd0, ap_idle}, 64'd1);
    check("t6_return", 64'(ap_return), 64'd6);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
